// File: rtl/counter_run_pkg.sv
// Shared encodings for the counter run controller: FSM state codes and a busy decode.
package counter_run_pkg;

    localparam int STATE_W = 2;

    // Code 3 is never entered; the controller treats it exactly like ST_IDLE.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } run_state_e;

    function automatic logic is_busy(input run_state_e s);
        return (s == ST_RUN) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/counter_run_core.sv
// Count register with clear and enable, plus an equality compare against the latched terminal value.
module counter_run_core #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [BITS-1:0] limit,
    output logic [BITS-1:0] count,
    output logic            at_limit
);

    // clr takes priority over en so a wrap or restart never leaks an increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + BITS'(1);
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/counter_run_ctrl.sv
// Start/stop/pause sequencer with prescaled advance, terminal detect and one-shot or periodic reload.
module counter_run_ctrl
    import counter_run_pkg::*;
#(
    parameter int BITS     = 32,
    parameter int PRE_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                periodic,
    input  logic [BITS-1:0]     load_val,
    input  logic [PRE_BITS-1:0] prescale,
    output logic [BITS-1:0]     count,
    output logic                busy,
    output logic                done,
    output logic [STATE_W-1:0]  state
);

    // start and stop are single-cycle command pulses acted on at the clock edge they are high;
    // there is no back-pressure, and when both are high stop wins in every state.

    run_state_e            state_q, state_d;
    logic [PRE_BITS-1:0]   pre_q, pre_d;
    logic [PRE_BITS-1:0]   pre_lim_q, pre_lim_d;
    logic [BITS-1:0]       limit_q, limit_d;
    logic                  mode_q, mode_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  cnt_clr, cnt_en;
    logic                  at_limit;
    logic                  tick;

    counter_run_core #(
        .BITS(BITS)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .limit    (limit_q),
        .count    (count),
        .at_limit (at_limit)
    );

    assign tick = (pre_q == pre_lim_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            pre_lim_q <= '0;
            limit_q   <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            pre_lim_q <= pre_lim_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        pre_lim_d = pre_lim_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (stop) begin
                    // Freeze count and prescaler; a tick landing on this edge is dropped.
                    state_d = ST_HOLD;
                end else if (start) begin
                    limit_d   = load_val;
                    pre_lim_d = prescale;
                    mode_d    = periodic;
                    pre_d     = '0;
                    cnt_clr   = 1'b1;
                end else if (tick) begin
                    pre_d = '0;
                    if (!at_limit) begin
                        cnt_en = 1'b1;
                    end else if (mode_q) begin
                        cnt_clr = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    pre_d = pre_q + PRE_BITS'(1);
                end
            end

            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    pre_d   = '0;
                    cnt_clr = 1'b1;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                // Covers ST_IDLE and the unused code 3.
                state_d = ST_IDLE;
                if (start && !stop) begin
                    limit_d   = load_val;
                    pre_lim_d = prescale;
                    mode_d    = periodic;
                    pre_d     = '0;
                    cnt_clr   = 1'b1;
                    state_d   = ST_RUN;
                end
            end
        endcase

        busy_d = is_busy(state_d);
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl: reset, one-shot, periodic, pause/resume/abort, command collisions.
module tb_counter_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        periodic;
    logic [31:0] load_val;
    logic [7:0]  prescale;
    logic [31:0] count;
    logic        busy;
    logic        done;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    counter_run_ctrl #(
        .BITS     (32),
        .PRE_BITS (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .load_val (load_val),
        .prescale (prescale),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] c, input logic b,
                             input logic d, input logic [1:0] s);
        check({tag, ".count"}, count, c);
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".state"}, 32'(state), 32'(s));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        load_val = 32'd0;
        prescale = 8'd0;
        step();
        step();
        check_all("reset", 32'd0, 1'b0, 1'b0, 2'd0);
        rst = 1'b1;
        step();
        check_all("post_reset_idle", 32'd0, 1'b0, 1'b0, 2'd0);

        // One-shot, limit 5, no prescale: done six edges after start, then count holds 5.
        load_val = 32'd5;
        prescale = 8'd0;
        periodic = 1'b0;
        pulse_start();
        check_all("os_start", 32'd0, 1'b1, 1'b0, 2'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_all($sformatf("os_edge%0d", k), 32'(k), 1'b1, 1'b0, 2'd1);
        end
        step();
        check_all("os_done", 32'd5, 1'b0, 1'b1, 2'd0);
        step();
        check_all("os_after", 32'd5, 1'b0, 1'b0, 2'd0);

        // Reset asserted for two edges while running.
        load_val = 32'd10;
        periodic = 1'b1;
        pulse_start();
        step();
        step();
        step();
        check("midrun_count", count, 32'd3);
        rst = 1'b0;
        step();
        step();
        check_all("midrun_reset", 32'd0, 1'b0, 1'b0, 2'd0);
        rst = 1'b1;
        step();
        check_all("midrun_reset_idle", 32'd0, 1'b0, 1'b0, 2'd0);

        // Periodic, limit 3, prescale 1: counts 0,0,1,1,2,2,3,3 with done every eighth edge.
        load_val = 32'd3;
        prescale = 8'd1;
        periodic = 1'b1;
        pulse_start();
        check_all("per_start", 32'd0, 1'b1, 1'b0, 2'd1);
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("per_cnt%0d", k), count, 32'((k / 2) % 4));
            check($sformatf("per_done%0d", k), 32'(done), 32'((k % 8) == 0));
        end

        // start and stop together: RUN -> HOLD, HOLD -> IDLE, IDLE stays IDLE.
        start = 1'b1;
        stop  = 1'b1;
        step();
        check_all("both_in_run", 32'd0, 1'b1, 1'b0, 2'd2);
        step();
        check_all("both_in_hold", 32'd0, 1'b0, 1'b0, 2'd0);
        step();
        check_all("both_in_idle", 32'd0, 1'b0, 1'b0, 2'd0);
        start = 1'b0;
        stop  = 1'b0;

        // Pause at 4, hold, resume without re-latching a new load_val, then abort.
        load_val = 32'd10;
        prescale = 8'd0;
        periodic = 1'b1;
        pulse_start();
        for (int k = 0; k < 4; k++) step();
        check("pause_pre", count, 32'd4);
        pulse_stop();
        check_all("pause_edge", 32'd4, 1'b1, 1'b0, 2'd2);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("pause_hold%0d", k), count, 32'd4);
        end
        load_val = 32'd5;
        pulse_start();
        check_all("resume_edge", 32'd4, 1'b1, 1'b0, 2'd1);
        step();
        check("resume_cnt5", count, 32'd5);
        step();
        check_all("resume_no_relatch", 32'd6, 1'b1, 1'b0, 2'd1);
        pulse_stop();
        check_all("hold_again", 32'd6, 1'b1, 1'b0, 2'd2);
        pulse_stop();
        check_all("abort", 32'd0, 1'b0, 1'b0, 2'd0);
        step();
        check_all("abort_idle", 32'd0, 1'b0, 1'b0, 2'd0);

        // Limit 0 periodic, no prescale: done every cycle, then restart with limit 2.
        load_val = 32'd0;
        periodic = 1'b1;
        pulse_start();
        check_all("lim0_start", 32'd0, 1'b1, 1'b0, 2'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_all($sformatf("lim0_edge%0d", k), 32'd0, 1'b1, 1'b1, 2'd1);
        end
        load_val = 32'd2;
        pulse_start();
        check_all("restart", 32'd0, 1'b1, 1'b0, 2'd1);
        step();
        check_all("restart_c1", 32'd1, 1'b1, 1'b0, 2'd1);
        step();
        check_all("restart_c2", 32'd2, 1'b1, 1'b0, 2'd1);
        step();
        check_all("restart_wrap", 32'd0, 1'b1, 1'b1, 2'd1);

        // stop in IDLE is ignored.
        pulse_stop();
        pulse_stop();
        check_all("stop_to_idle", 32'd0, 1'b0, 1'b0, 2'd0);
        pulse_stop();
        check_all("stop_in_idle", 32'd0, 1'b0, 1'b0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
